// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: shared state type, latched-config struct and width helpers
// for the pulse-train generator.
// Optional feature macro: PULSE_TRAIN_REPEAT_EN (adds the per-channel repeat bit).
package pulse_train_pkg;

  localparam int PT_CNT_W   = 16;
  localparam int PT_WIDTH_W = 16;
  // One extra bit so 2*cnt + 1 always fits.
  localparam int PT_FLIP_W  = PT_CNT_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pt_state_e;

  // Config captured on an accepted start; sized for the package widths.
  typedef struct packed {
    logic [PT_CNT_W-1:0]   cnt;
    logic [PT_WIDTH_W-1:0] hi;
    logic [PT_WIDTH_W-1:0] lo;
    logic                  spol;
    logic                  epol;
`ifdef PULSE_TRAIN_REPEAT_EN
    logic                  rpt;
`endif
  } pt_cfg_t;

  // Total number of output flips for one train.
  function automatic logic [PT_FLIP_W-1:0] flip_count(input pt_cfg_t c);
    return {c.cnt, 1'b0} + PT_FLIP_W'(c.spol ^ c.epol);
  endfunction

  // Phase down-counter load value; a width of 0 behaves like 1.
  function automatic logic [PT_WIDTH_W-1:0] hold_load(input logic [PT_WIDTH_W-1:0] w);
    return (w == '0) ? '0 : w - PT_WIDTH_W'(1);
  endfunction

endpackage

// File: rtl/pulse_train_ch.sv
// pulse_train_ch: one pulse-train channel (FSM, phase down-counter, flip counter).
// Optional feature macro: PULSE_TRAIN_REPEAT_EN (cfg_repeat input, continuous trains).
//
// state | meaning
// IDLE  | output holds last level, waiting for start
// RUN   | train in progress, busy high, phase counter timing each level
module pulse_train_ch
  import pulse_train_pkg::*;
#(
  parameter int CntW   = PT_CNT_W,
  parameter int WidthW = PT_WIDTH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CntW-1:0]   cfg_cnt,
  input  logic [WidthW-1:0] cfg_hi,
  input  logic [WidthW-1:0] cfg_lo,
  input  logic              cfg_spol,
  input  logic              cfg_epol,
`ifdef PULSE_TRAIN_REPEAT_EN
  input  logic              cfg_repeat,
`endif
  output logic              pulse_o,
  output logic              busy,
  output logic              done
);

  pt_state_e             state_q, state_d;
  pt_cfg_t               cfg_q, cfg_d, new_cfg;
  logic [PT_FLIP_W-1:0]  rem_q, rem_d;      // flips still to take, current one excluded
  logic [PT_FLIP_W-1:0]  new_flips;
  logic [PT_WIDTH_W-1:0] phase_q, phase_d;  // cycles left in the current level, minus one
  logic                  pulse_q, pulse_d;
  logic                  done_q, done_d;
  logic                  repeat_eff;

`ifdef PULSE_TRAIN_REPEAT_EN
  assign repeat_eff = cfg_q.rpt && (cfg_q.spol == cfg_q.epol);
`else
  assign repeat_eff = 1'b0;
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    rem_d        = rem_q;
    phase_d      = phase_q;
    pulse_d      = pulse_q;
    done_d       = 1'b0;
    new_cfg      = '0;
    new_cfg.cnt  = PT_CNT_W'(cfg_cnt);
    new_cfg.hi   = PT_WIDTH_W'(cfg_hi);
    new_cfg.lo   = PT_WIDTH_W'(cfg_lo);
    new_cfg.spol = cfg_spol;
    new_cfg.epol = cfg_epol;
`ifdef PULSE_TRAIN_REPEAT_EN
    new_cfg.rpt  = cfg_repeat;
`endif
    new_flips    = flip_count(new_cfg);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_d = new_cfg;
          if (new_flips == '0) begin
            pulse_d = new_cfg.spol;
            done_d  = 1'b1;
          end else if (new_flips == PT_FLIP_W'(1)) begin
            // Single flip is also the last one: no RUN phase.
            pulse_d = new_cfg.epol;
            done_d  = 1'b1;
          end else begin
            pulse_d = ~new_cfg.spol;
            rem_d   = new_flips - PT_FLIP_W'(1);
            phase_d = hold_load(new_cfg.hi);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          pulse_d = cfg_q.epol;
          rem_d   = '0;
          phase_d = '0;
          state_d = IDLE;
        end else if (phase_q != '0) begin
          phase_d = phase_q - PT_WIDTH_W'(1);
        end else if (rem_q == PT_FLIP_W'(1)) begin
          pulse_d = cfg_q.epol;
          done_d  = 1'b1;
          if (repeat_eff) begin
            // Hold the end level for lo cycles, then the next flip is flip 1 again.
            rem_d   = flip_count(cfg_q);
            phase_d = hold_load(cfg_q.lo);
          end else begin
            rem_d   = '0;
            phase_d = '0;
            state_d = IDLE;
          end
        end else begin
          rem_d   = rem_q - PT_FLIP_W'(1);
          pulse_d = ~pulse_q;
          // Leaving the idle level means entering the active phase.
          phase_d = (pulse_q == cfg_q.spol) ? hold_load(cfg_q.hi) : hold_load(cfg_q.lo);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      rem_q   <= '0;
      phase_q <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: NumCh independent pulse-train channels side by side.
// Optional feature macro: PULSE_TRAIN_REPEAT_EN (adds cfg_repeat per channel).
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int NumCh  = 4,
  parameter int CntW   = PT_CNT_W,
  parameter int WidthW = PT_WIDTH_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NumCh-1:0]             start,
  input  logic [NumCh-1:0]             abort,
  input  logic [NumCh-1:0][CntW-1:0]   cfg_cnt,
  input  logic [NumCh-1:0][WidthW-1:0] cfg_hi,
  input  logic [NumCh-1:0][WidthW-1:0] cfg_lo,
  input  logic [NumCh-1:0]             cfg_spol,
  input  logic [NumCh-1:0]             cfg_epol,
`ifdef PULSE_TRAIN_REPEAT_EN
  input  logic [NumCh-1:0]             cfg_repeat,
`endif
  output logic [NumCh-1:0]             pulse_o,
  output logic [NumCh-1:0]             busy,
  output logic [NumCh-1:0]             done
);

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    pulse_train_ch #(
      .CntW  (CntW),
      .WidthW(WidthW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .start     (start[i]),
      .abort     (abort[i]),
      .cfg_cnt   (cfg_cnt[i]),
      .cfg_hi    (cfg_hi[i]),
      .cfg_lo    (cfg_lo[i]),
      .cfg_spol  (cfg_spol[i]),
      .cfg_epol  (cfg_epol[i]),
`ifdef PULSE_TRAIN_REPEAT_EN
      .cfg_repeat(cfg_repeat[i]),
`endif
      .pulse_o   (pulse_o[i]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end

endmodule
